trail_writer: RTL and testbench
===============================

Name: trail_writer

Overview:
- Write-side master for the shared frameRAM frame buffer; the display-side read path consumes what it writes.
- After reset, or on request, it sweeps the whole buffer to the background colour.
- On each game frame, it plots a 2x2-pixel trail block at the current blue and red bike positions.
- It drives the frameRAM write port (write_address / Data_In / WE) using the same packing as the read path: even-X pixel in bits [3:0], odd-X pixel in bits [11:8], all other bits 0.

Parameters:
- H_RES, 640: visible width in pixels.
- V_RES, 480: visible height in pixels.
- BG_COLOR, 4'h8: background colour index used by the clear sweep.
- BLUE_COLOR, 4'h6: blue trail colour index.
- RED_COLOR, 4'h4: red trail colour index.
- TRAIL_ROWS, 2: rows written per bike per frame (1..4).

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset; all state is cleared while it is 0.
- frame_clk  in  1  ~60 Hz frame tick, asynchronous to Clk.
- Run  in  1  1 = plot trails on frame ticks; 0 = paused.
- clear_req  in  1  single-cycle request to re-clear the buffer.
- Blue_X_real, Blue_Y_real  in  10 each  blue bike pixel position.
- Red_X_real, Red_Y_real  in  10 each  red bike pixel position.
- write_address  out  19  frameRAM word address.
- Data_In  out  16  frameRAM write data.
- WE  out  1  frameRAM write enable.
- busy  out  1  high in any state other than IDLE.
- clear_done  out  1  one-cycle pulse when a clear sweep completes.

Behaviour:
- Reset values: all outputs are registered and reset to 0. The FSM resets into CLEAR with the sweep counter at 0.
- Address formula: word address = X/2 + Y*(H_RES/2), using truncating division. Words total = H_RES*V_RES/2 = 76800 by default.
- Packed word: {4'h0, C, 4'h0, C}, where C is the colour. Both pixels of the word are written with the same colour, so trail width is 2 pixels. No read-modify-write is performed.
- Frame tick detection:
  - frame_clk passes through a 2-flop synchroniser, then an edge-detect flop.
  - tick = sync2 & ~prev, high for one Clk cycle.
- States: CLEAR, IDLE, PLOT, DONE.
- CLEAR:
  - Each cycle: WE=1, write_address = counter, Data_In = {4'h0,BG_COLOR,4'h0,BG_COLOR}; counter increments.
  - After the write at address 76799: go to DONE and pulse clear_done for 1 cycle (WE=0 in DONE).
  - Ticks and clear_req arriving during CLEAR are dropped.
- DONE: lasts one cycle, then IDLE.
- IDLE (busy=0, WE=0):
  - clear_req=1: reset counter to 0 and go to CLEAR. clear_req wins over a tick in the same cycle; that tick is dropped.
  - Otherwise, tick=1 and Run=1: latch all four position inputs into internal registers and go to PLOT.
  - tick=1 and Run=0: ignored.
- PLOT:
  - Exactly 2*TRAIL_ROWS consecutive slots, in order: blue rows 0..TRAIL_ROWS-1, then red rows 0..TRAIL_ROWS-1. Each slot uses the latched X and latched Y + row.
  - A slot with X >= H_RES or Y+row >= V_RES drives WE=0 but still consumes its cycle, so PLOT length is fixed.
  - Y+row is computed at 11 bits so no wrap occurs.
  - After the last slot, go to IDLE. Ticks and clear_req during PLOT are dropped.
- Latency: first PLOT write occurs 1 cycle after the latch cycle. Inputs may change after the latch cycle without affecting the current frame's writes.
- Overlap: if blue and red hit the same word, red is written last and wins.
- Reset mid-operation: asynchronous abort; WE drops to 0 immediately; restart from CLEAR at address 0.

Test Plan:
- Release Reset -> 76800 consecutive WE=1 cycles, addresses 0..76799, Data_In=16'h0808; then clear_done is high for exactly 1 cycle; then busy=0.
- Run=1, blue=(100,50), red=(301,200), frame_clk rising -> writes in order: 16050/16'h0606, 16370/16'h0606, 64150/16'h0404, 64470/16'h0404 on 4 consecutive cycles; then busy=0.
- Blue=(200,479), red=(640,10) -> blue row0 written at 153380/16'h0606; blue row1 and both red slots have WE=0; PLOT still lasts 4 cycles.
- Run=0 with frame_clk toggling -> no WE and busy stays 0. clear_req and tick in the same IDLE cycle -> full clear sweep and no trail writes.
- Positions changed on the cycle after the tick -> written addresses still match the latched values. Blue=red=(100,50) -> address 16050 is written 16'h0606, then 16'h0404.
- Reset asserted at clear address 1000 or mid-PLOT -> WE=0 immediately; after release, the clear sweep restarts at address 0.

Source files
------------

// File: rtl/trail_writer.sv
// trail_writer: write-side master for the shared frameRAM frame buffer.
// After reset (or on clear_req) it sweeps every word to the background colour,
// then on each frame tick (while Run=1) plots a 2-pixel-wide, TRAIL_ROWS-tall
// block at the latched blue and red bike positions. Red is plotted last.
//
// Ports:
//   Clk, Reset           clock, asynchronous active-low reset
//   frame_clk            ~60 Hz frame tick, asynchronous to Clk
//   Run                  1 = plot on frame ticks, 0 = paused
//   clear_req            single-cycle request to re-clear the buffer
//   Blue_X_real/_Y_real  blue bike pixel position
//   Red_X_real/_Y_real   red bike pixel position
//   write_address        frameRAM word address (X/2 + Y*H_RES/2)
//   Data_In              frameRAM write data {4'h0, C, 4'h0, C}
//   WE                   frameRAM write enable
//   busy                 high while not idle
//   clear_done           one-cycle pulse after a clear sweep completes
module trail_writer #(
    parameter int unsigned H_RES      = 640,
    parameter int unsigned V_RES      = 480,
    parameter logic [3:0]  BG_COLOR   = 4'h8,
    parameter logic [3:0]  BLUE_COLOR = 4'h6,
    parameter logic [3:0]  RED_COLOR  = 4'h4,
    parameter int unsigned TRAIL_ROWS = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic        Run,
    input  logic        clear_req,
    input  logic [9:0]  Blue_X_real,
    input  logic [9:0]  Blue_Y_real,
    input  logic [9:0]  Red_X_real,
    input  logic [9:0]  Red_Y_real,
    output logic [18:0] write_address,
    output logic [15:0] Data_In,
    output logic        WE,
    output logic        busy,
    output logic        clear_done
);

    localparam int unsigned WORDS     = H_RES * V_RES / 2;
    localparam logic [18:0] LAST_ADDR = 19'(WORDS - 1);
    localparam logic [2:0]  LAST_SLOT = 3'(2 * TRAIL_ROWS - 1);
    localparam logic [2:0]  ROWS      = 3'(TRAIL_ROWS);
    localparam logic [15:0] BG_WORD   = {4'h0, BG_COLOR, 4'h0, BG_COLOR};

    typedef enum logic [1:0] {StClear, StIdle, StPlot, StDone} state_t;

    state_t      state_q;
    logic [18:0] counter_q;
    logic [2:0]  slot_q;
    logic [9:0]  blue_x_q, blue_y_q, red_x_q, red_y_q;

    // frame_clk synchroniser and rising-edge detect
    logic sync1_q, sync2_q, prev_q;
    logic tick;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= frame_clk;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign tick = sync2_q & ~prev_q;

    // Current PLOT slot: blue rows first, then red rows.
    logic [9:0]  slot_x, slot_y;
    logic [2:0]  slot_row;
    logic [3:0]  slot_color;
    logic [10:0] slot_y_row;
    logic        slot_valid;
    logic [18:0] slot_addr;

    always_comb begin
        slot_x     = blue_x_q;
        slot_y     = blue_y_q;
        slot_color = BLUE_COLOR;
        slot_row   = slot_q;
        if (slot_q >= ROWS) begin
            slot_x     = red_x_q;
            slot_y     = red_y_q;
            slot_color = RED_COLOR;
            slot_row   = slot_q - ROWS;
        end
        // 11-bit row sum so Y near the bottom cannot wrap back on-screen
        slot_y_row = {1'b0, slot_y} + 11'(slot_row);
        slot_valid = (32'(slot_x) < H_RES) && (32'(slot_y_row) < V_RES);
        slot_addr  = 19'(slot_x >> 1) + 19'(slot_y_row) * 19'(H_RES / 2);
    end

    // Outputs are registered images of what the state did on the previous
    // cycle, so busy lags the state by one cycle and lines up with WE.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q       <= StClear;
            counter_q     <= '0;
            slot_q        <= '0;
            blue_x_q      <= '0;
            blue_y_q      <= '0;
            red_x_q       <= '0;
            red_y_q       <= '0;
            write_address <= '0;
            Data_In       <= '0;
            WE            <= 1'b0;
            busy          <= 1'b0;
            clear_done    <= 1'b0;
        end else begin
            WE         <= 1'b0;
            clear_done <= 1'b0;
            busy       <= (state_q != StIdle);
            case (state_q)
                StClear: begin
                    WE            <= 1'b1;
                    write_address <= counter_q;
                    Data_In       <= BG_WORD;
                    if (counter_q == LAST_ADDR) begin
                        state_q <= StDone;
                    end else begin
                        counter_q <= counter_q + 19'd1;
                    end
                end
                StDone: begin
                    clear_done <= 1'b1;
                    state_q    <= StIdle;
                end
                StIdle: begin
                    // clear_req has priority; a coincident tick is dropped
                    if (clear_req) begin
                        counter_q <= '0;
                        state_q   <= StClear;
                    end else if (tick && Run) begin
                        blue_x_q <= Blue_X_real;
                        blue_y_q <= Blue_Y_real;
                        red_x_q  <= Red_X_real;
                        red_y_q  <= Red_Y_real;
                        slot_q   <= '0;
                        state_q  <= StPlot;
                    end
                end
                StPlot: begin
                    // off-screen slots still take their cycle: fixed PLOT length
                    WE            <= slot_valid;
                    write_address <= slot_addr;
                    Data_In       <= {4'h0, slot_color, 4'h0, slot_color};
                    if (slot_q == LAST_SLOT) begin
                        state_q <= StIdle;
                    end else begin
                        slot_q <= slot_q + 3'd1;
                    end
                end
                default: state_q <= StClear;
            endcase
        end
    end

endmodule

// File: tb/tb_trail_writer.sv
// Directed self-checking bench for trail_writer. The buffer height is reduced
// to 32 rows (10240 words) so several full clear sweeps stay short; width is
// kept at 640 so the row stride is 320 words.
module tb_trail_writer;

    localparam int unsigned H = 640;
    localparam int unsigned V = 32;
    localparam int unsigned WORDS = H * V / 2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        frame_clk;
    logic        Run;
    logic        clear_req;
    logic [9:0]  Blue_X_real, Blue_Y_real, Red_X_real, Red_Y_real;
    logic [18:0] write_address;
    logic [15:0] Data_In;
    logic        WE;
    logic        busy;
    logic        clear_done;

    int total = 0;
    int bad   = 0;

    trail_writer #(
        .H_RES     (H),
        .V_RES     (V),
        .BG_COLOR  (4'h8),
        .BLUE_COLOR(4'h6),
        .RED_COLOR (4'h4),
        .TRAIL_ROWS(2)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .Run          (Run),
        .clear_req    (clear_req),
        .Blue_X_real  (Blue_X_real),
        .Blue_Y_real  (Blue_Y_real),
        .Red_X_real   (Red_X_real),
        .Red_Y_real   (Red_Y_real),
        .write_address(write_address),
        .Data_In      (Data_In),
        .WE           (WE),
        .busy         (busy),
        .clear_done   (clear_done)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic set_pos(input int bx, input int by, input int rx, input int ry);
        Blue_X_real = 10'(bx);
        Blue_Y_real = 10'(by);
        Red_X_real  = 10'(rx);
        Red_Y_real  = 10'(ry);
    endtask

    // Expect a full clear sweep 0..WORDS-1 of 16'h0808, then clear_done, then idle.
    task automatic check_sweep(input string tag);
        int n    = 0;
        int errs = 0;
        int cyc  = 0;
        while (!WE && cyc < 20) begin
            @(negedge Clk);
            cyc++;
        end
        while (WE && n < int'(WORDS) + 5) begin
            if (write_address !== 19'(n) || Data_In !== 16'h0808) errs++;
            n++;
            @(negedge Clk);
        end
        chk({tag, "_len"}, n, WORDS);
        chk({tag, "_data"}, errs, 0);
        chk({tag, "_done_hi"}, {31'd0, clear_done}, 1);
        chk({tag, "_busy_at_done"}, {31'd0, busy}, 1);
        @(negedge Clk);
        chk({tag, "_done_lo"}, {31'd0, clear_done}, 0);
        chk({tag, "_busy_lo"}, {31'd0, busy}, 0);
    endtask

    // Raise frame_clk and check the four PLOT slots (blue, blue, red, red).
    task automatic plot_frame(input string tag, input logic [18:0] a0, input logic [18:0] a1,
                              input logic [18:0] a2, input logic [18:0] a3,
                              input logic [3:0] we_exp, input bit scramble);
        logic [18:0] a [4];
        logic [15:0] d [4];
        int cyc = 0;
        a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
        d[0] = 16'h0606; d[1] = 16'h0606; d[2] = 16'h0404; d[3] = 16'h0404;
        frame_clk = 1'b1;
        repeat (3) @(negedge Clk);
        // positions latched on the previous edge; later changes must not matter
        if (scramble) set_pos(7, 3, 9, 5);
        while (!busy && cyc < 10) begin
            @(negedge Clk);
            cyc++;
        end
        chk({tag, "_busy_start"}, {31'd0, busy}, 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_we%0d", tag, i), {31'd0, WE}, {31'd0, we_exp[i]});
            if (we_exp[i]) begin
                chk($sformatf("%s_addr%0d", tag, i), {13'd0, write_address}, {13'd0, a[i]});
                chk($sformatf("%s_data%0d", tag, i), {16'd0, Data_In}, {16'd0, d[i]});
            end
            @(negedge Clk);
        end
        chk({tag, "_busy_end"}, {31'd0, busy}, 0);
        chk({tag, "_we_end"}, {31'd0, WE}, 0);
        frame_clk = 1'b0;
        repeat (5) @(negedge Clk);
    endtask

    initial begin
        int hits;
        int cyc;
        Reset = 1'b0; frame_clk = 1'b0; Run = 1'b0; clear_req = 1'b0;
        set_pos(0, 0, 0, 0);
        repeat (3) @(negedge Clk);
        chk("rst_we", {31'd0, WE}, 0);
        chk("rst_addr", {13'd0, write_address}, 0);
        chk("rst_data", {16'd0, Data_In}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, clear_done}, 0);

        Reset = 1'b1;
        check_sweep("sweep0");

        // basic frame: blue (100,20) -> 50+6400, 50+6720; red (301,25) -> 150+8000, 150+8320
        Run = 1'b1;
        set_pos(100, 20, 301, 25);
        plot_frame("plot1", 19'd6450, 19'd6770, 19'd8150, 19'd8470, 4'b1111, 1'b0);

        // bottom edge and right edge: only blue row 0 lands on screen
        set_pos(200, 31, 640, 10);
        plot_frame("edge", 19'd10020, 19'd0, 19'd0, 19'd0, 4'b0001, 1'b0);

        // inputs change right after the latch
        set_pos(100, 20, 301, 25);
        plot_frame("latch", 19'd6450, 19'd6770, 19'd8150, 19'd8470, 4'b1111, 1'b1);

        // overlap: red rewrites the same words after blue
        set_pos(100, 20, 100, 20);
        plot_frame("ovl", 19'd6450, 19'd6770, 19'd6450, 19'd6770, 4'b1111, 1'b0);

        // paused: ticks ignored
        Run = 1'b0;
        set_pos(100, 20, 301, 25);
        hits = 0;
        for (int k = 0; k < 3; k++) begin
            frame_clk = 1'b1;
            repeat (5) begin @(negedge Clk); if (WE || busy) hits++; end
            frame_clk = 1'b0;
            repeat (5) begin @(negedge Clk); if (WE || busy) hits++; end
        end
        chk("paused_quiet", hits, 0);
        Run = 1'b1;

        // clear_req in the same IDLE cycle as a tick: clear wins, tick dropped
        frame_clk = 1'b1;
        repeat (2) @(negedge Clk);
        clear_req = 1'b1;
        @(negedge Clk);
        clear_req = 1'b0;
        check_sweep("sweep_req");
        frame_clk = 1'b0;
        hits = 0;
        repeat (10) begin @(negedge Clk); if (WE || busy) hits++; end
        chk("no_plot_after_req", hits, 0);

        // reset during the sweep at address 1000
        clear_req = 1'b1;
        @(negedge Clk);
        clear_req = 1'b0;
        cyc = 0;
        while (!(WE && write_address == 19'd1000) && cyc < 1100) begin
            @(negedge Clk);
            cyc++;
        end
        chk("reached_1000", {13'd0, write_address}, 1000);
        Reset = 1'b0;
        #1;
        chk("rst_sweep_we", {31'd0, WE}, 0);
        chk("rst_sweep_addr", {13'd0, write_address}, 0);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        check_sweep("sweep_after_rst");

        // reset in the middle of PLOT
        set_pos(100, 20, 301, 25);
        frame_clk = 1'b1;
        cyc = 0;
        while (!busy && cyc < 10) begin
            @(negedge Clk);
            cyc++;
        end
        @(negedge Clk);
        chk("midplot_we", {31'd0, WE}, 1);
        chk("midplot_addr", {13'd0, write_address}, 6770);
        Reset = 1'b0;
        #1;
        chk("rst_plot_we", {31'd0, WE}, 0);
        chk("rst_plot_busy", {31'd0, busy}, 0);
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        check_sweep("sweep_after_plot_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
